// File: rtl/drbg_line_key_scheduler.sv
// Sequences the hash DRBG for the line scrambler: init, one prefetched key released per
// line_start, and a reseed strobe every FIELDS_PER_RESEED fields.
module drbg_line_key_scheduler #(
   parameter int KEY_W             = 32,
   parameter int FIELDS_PER_RESEED = 4,
   parameter int TIMEOUT_CYCLES    = 4096
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             field_start,
   input  logic             line_start,
   input  logic             drbg_init_ready,
   input  logic             drbg_next_bits_ready,
   input  logic [255:0]     drbg_random_bits,
   output logic             drbg_init,
   output logic             drbg_next_bits,
   output logic             drbg_next_seed,
   output logic [KEY_W-1:0] line_key,
   output logic             line_key_valid,
   output logic             key_underrun,
   output logic             fault,
   output logic [15:0]      underrun_count
);

   localparam int FCW = (FIELDS_PER_RESEED > 1) ? $clog2(FIELDS_PER_RESEED) : 1;
   localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [FCW-1:0] FIELD_LAST = FCW'(FIELDS_PER_RESEED - 1);
   localparam logic [FCW-1:0] FIELD_ONE  = FCW'(1);
   localparam logic [TCW-1:0] TIMER_LAST = TCW'(TIMEOUT_CYCLES - 1);
   localparam logic [TCW-1:0] TIMER_ONE  = TCW'(1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_INIT    = 3'd1;
   localparam logic [2:0] S_FETCH   = 3'd2;
   localparam logic [2:0] S_RELEASE = 3'd3;
   localparam logic [2:0] S_FULL    = 3'd4;
   localparam logic [2:0] S_SEED    = 3'd5;
   localparam logic [2:0] S_FAULT   = 3'd6;

   logic [2:0]       r_state;
   logic [2:0]       w_next;
   logic [TCW-1:0]   r_timer;
   logic [FCW-1:0]   r_field_cnt;
   logic             r_reseed_pending;
   logic [KEY_W-1:0] r_buf;
   logic             r_buf_valid;
   logic [KEY_W-1:0] r_line_key;
   logic             r_line_key_valid;
   logic             r_key_underrun;
   logic [15:0]      r_underrun_count;

   logic w_serve;
   logic w_underrun;
   logic w_field_wrap;
   logic w_waiting;
   logic w_timeout;
   logic w_capture;
   logic w_unused_bits;

   assign w_serve      = enable && line_start && r_buf_valid;
   assign w_underrun   = enable && line_start && !r_buf_valid;
   assign w_field_wrap = enable && field_start && (r_field_cnt == FIELD_LAST);
   assign w_waiting    = (r_state == S_INIT) || (r_state == S_FETCH) || (r_state == S_RELEASE);
   assign w_timeout    = (r_timer == TIMER_LAST);
   assign w_capture    = (r_state == S_FETCH) && drbg_next_bits_ready;
   assign w_unused_bits = ^drbg_random_bits;

   // A wrap seen while in S_FULL goes straight to S_SEED so the reseed precedes the refill.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    w_next = S_INIT;
         S_INIT:    if (drbg_init_ready) w_next = S_FETCH;
                    else if (w_timeout) w_next = S_FAULT;
         S_FETCH:   if (drbg_next_bits_ready) w_next = S_RELEASE;
                    else if (w_timeout) w_next = S_FAULT;
         S_RELEASE: if (!drbg_next_bits_ready) w_next = S_FULL;
                    else if (w_timeout) w_next = S_FAULT;
         S_FULL:    if (r_reseed_pending || w_field_wrap) w_next = S_SEED;
                    else if (w_serve || !r_buf_valid) w_next = S_FETCH;
         S_SEED:    w_next = (r_buf_valid && !w_serve) ? S_FULL : S_FETCH;
         S_FAULT:   w_next = S_FAULT;
         default:   w_next = S_IDLE;
      endcase
      if (!enable) w_next = S_IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state          <= S_IDLE;
         r_timer          <= '0;
         r_field_cnt      <= '0;
         r_reseed_pending <= 1'b0;
         r_buf            <= '0;
         r_buf_valid      <= 1'b0;
         r_line_key       <= '0;
         r_line_key_valid <= 1'b0;
         r_key_underrun   <= 1'b0;
         r_underrun_count <= '0;
      end else begin
         r_state          <= w_next;
         r_timer          <= ((w_next != r_state) || !w_waiting) ? '0 : r_timer + TIMER_ONE;
         r_line_key_valid <= w_serve;
         r_key_underrun   <= w_underrun;
         if (w_serve) r_line_key <= r_buf;
         if (w_underrun && (r_underrun_count != 16'hFFFF))
            r_underrun_count <= r_underrun_count + 16'd1;

         if (!enable) begin
            r_buf_valid <= 1'b0;
         end else if (w_capture) begin
            r_buf       <= drbg_random_bits[KEY_W-1:0];
            r_buf_valid <= 1'b1;
         end else if (w_serve) begin
            r_buf_valid <= 1'b0;
         end

         // A wrap landing in the S_SEED cycle must survive the clear.
         if (!enable) begin
            r_field_cnt      <= '0;
            r_reseed_pending <= 1'b0;
         end else begin
            if (field_start) r_field_cnt <= w_field_wrap ? '0 : r_field_cnt + FIELD_ONE;
            if (w_field_wrap) r_reseed_pending <= 1'b1;
            else if (r_state == S_SEED) r_reseed_pending <= 1'b0;
         end
      end
   end

   assign drbg_init      = (r_state == S_INIT);
   assign drbg_next_bits = (r_state == S_FETCH);
   assign drbg_next_seed = (r_state == S_SEED);
   assign fault          = (r_state == S_FAULT);
   assign line_key       = r_line_key;
   assign line_key_valid = r_line_key_valid;
   assign key_underrun   = r_key_underrun;
   assign underrun_count = r_underrun_count;

endmodule

// File: tb/tb_drbg_line_key_scheduler.sv
// Bench for drbg_line_key_scheduler: behavioural DRBG model pushes each delivered key into a
// scoreboard queue; scenario tasks pop and compare when line_key_valid fires.
module tb_drbg_line_key_scheduler;

   localparam int KEY_W    = 32;
   localparam int FPR      = 4;
   localparam int TMO      = 16;
   localparam int INIT_LAT = 10;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         enable = 1'b0;
   logic         field_start = 1'b0;
   logic         line_start = 1'b0;
   logic         init_ready;
   logic         bits_ready;
   logic [255:0] bits;
   logic         drbg_init;
   logic         drbg_next_bits;
   logic         drbg_next_seed;
   logic [KEY_W-1:0] line_key;
   logic         line_key_valid;
   logic         key_underrun;
   logic         fault;
   logic [15:0]  underrun_count;

   int checks = 0;
   int errors = 0;
   int bits_lat = 4;
   bit never_ready = 1'b0;
   logic [31:0] model_key = 32'hDEADBEEF;
   logic [31:0] exp_q[$];
   logic [31:0] last_key;
   int init_cnt;
   int bits_cnt;
   int seed_cnt = 0;
   int seed_long = 0;
   int seed_overlap = 0;
   bit prev_seed = 1'b0;

   drbg_line_key_scheduler #(
      .KEY_W             (KEY_W),
      .FIELDS_PER_RESEED (FPR),
      .TIMEOUT_CYCLES    (TMO)
   ) dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .enable               (enable),
      .field_start          (field_start),
      .line_start           (line_start),
      .drbg_init_ready      (init_ready),
      .drbg_next_bits_ready (bits_ready),
      .drbg_random_bits     (bits),
      .drbg_init            (drbg_init),
      .drbg_next_bits       (drbg_next_bits),
      .drbg_next_seed       (drbg_next_seed),
      .line_key             (line_key),
      .line_key_valid       (line_key_valid),
      .key_underrun         (key_underrun),
      .fault                (fault),
      .underrun_count       (underrun_count)
   );

   always #5 clk = ~clk;

   // DRBG model: ready rises LAT edges after the request is first seen, drops when request drops.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         init_ready <= 1'b0;
         bits_ready <= 1'b0;
         bits       <= '0;
         init_cnt   <= 0;
         bits_cnt   <= 0;
      end else begin
         if (!drbg_init) begin
            init_ready <= 1'b0;
            init_cnt   <= 0;
         end else if (!init_ready && !never_ready) begin
            if (init_cnt == INIT_LAT - 1) init_ready <= 1'b1;
            init_cnt <= init_cnt + 1;
         end
         if (!drbg_next_bits) begin
            bits_ready <= 1'b0;
            bits_cnt   <= 0;
         end else if (!bits_ready && !never_ready) begin
            if (bits_cnt == bits_lat - 1) begin
               bits_ready <= 1'b1;
               bits       <= {{7{~model_key}}, model_key};
               exp_q.push_back(model_key);
               model_key  <= model_key + 32'h01010101;
            end
            bits_cnt <= bits_cnt + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (drbg_next_seed) seed_cnt++;
      if (drbg_next_seed && prev_seed) seed_long++;
      if (drbg_next_seed && drbg_next_bits) seed_overlap++;
      prev_seed = drbg_next_seed;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_refill(input string tag);
      int t = 0;
      while (exp_q.size() == 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s_refill: no key delivered after %0d cycles, required 1", tag, t);
      end
      cyc(4);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      cyc(5);
      checks++;
      if ({drbg_init, drbg_next_bits, drbg_next_seed} !== 3'b000) begin
         errors++;
         $display("FAIL reset_requests: got %b required 000", {drbg_init, drbg_next_bits, drbg_next_seed});
      end
      checks++;
      if ({line_key, line_key_valid, key_underrun, fault, underrun_count} !== '0) begin
         errors++;
         $display("FAIL reset_status: key %h valid %b under %b fault %b cnt %0d required all 0",
                  line_key, line_key_valid, key_underrun, fault, underrun_count);
      end
   endtask

   task automatic test_init();
      int held = 0;
      reset_n = 1'b1;
      cyc(1);
      enable = 1'b1;
      @(negedge clk);
      while (drbg_init === 1'b1 && held < 100) begin
         held++;
         @(negedge clk);
      end
      checks++;
      if (held != INIT_LAT + 1) begin
         errors++;
         $display("FAIL init_hold: drbg_init high %0d cycles, required %0d", held, INIT_LAT + 1);
      end
      wait_refill("init");
      checks++;
      if (exp_q.size() != 1 || drbg_next_bits !== 1'b0 || drbg_init !== 1'b0) begin
         errors++;
         $display("FAIL init_full: keys %0d next_bits %b init %b, required 1 0 0",
                  exp_q.size(), drbg_next_bits, drbg_init);
      end
   endtask

   task automatic test_serve();
      logic [31:0] exp = '0;
      logic got_req;
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      line_start = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
      checks++;
      if (line_key_valid !== 1'b1 || line_key !== exp) begin
         errors++;
         $display("FAIL serve_key: valid %b key %h, required 1 %h", line_key_valid, line_key, exp);
      end
      checks++;
      if (line_key !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL serve_first: key %h, required deadbeef", line_key);
      end
      got_req = drbg_next_bits;
      @(negedge clk);
      got_req = got_req | drbg_next_bits;
      checks++;
      if (line_key_valid !== 1'b0 || got_req !== 1'b1) begin
         errors++;
         $display("FAIL serve_strobe: valid %b refetch %b, required 0 1", line_key_valid, got_req);
      end
      last_key = exp;
      wait_refill("serve");
   endtask

   task automatic test_underrun();
      logic [31:0] exp = '0;
      bits_lat = 14;
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      line_start = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
      checks++;
      if (line_key_valid !== 1'b1 || line_key !== exp) begin
         errors++;
         $display("FAIL under_first: valid %b key %h, required 1 %h", line_key_valid, line_key, exp);
      end
      @(negedge clk);
      line_start = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
      checks++;
      if (key_underrun !== 1'b1 || line_key_valid !== 1'b0 || line_key !== exp || underrun_count !== 16'd1) begin
         errors++;
         $display("FAIL under_second: under %b valid %b key %h cnt %0d, required 1 0 %h 1",
                  key_underrun, line_key_valid, line_key, underrun_count, exp);
      end
      @(negedge clk);
      checks++;
      if (key_underrun !== 1'b0) begin
         errors++;
         $display("FAIL under_strobe: under %b, required 0", key_underrun);
      end
      last_key = exp;
      wait_refill("under");
      bits_lat = 4;
   endtask

   task automatic test_reseed();
      int s0 = seed_cnt;
      int l0 = seed_long;
      int o0 = seed_overlap;
      repeat (2 * FPR) begin
         field_start = 1'b1;
         @(negedge clk);
         field_start = 1'b0;
         cyc(3);
      end
      cyc(5);
      checks++;
      if (seed_cnt - s0 != 2) begin
         errors++;
         $display("FAIL reseed_count: %0d strobes, required 2", seed_cnt - s0);
      end
      checks++;
      if (seed_long != l0 || seed_overlap != o0) begin
         errors++;
         $display("FAIL reseed_shape: long %0d overlap %0d, required 0 0", seed_long - l0, seed_overlap - o0);
      end
      checks++;
      if (exp_q.size() != 1 || drbg_next_bits !== 1'b0) begin
         errors++;
         $display("FAIL reseed_keep: keys %0d next_bits %b, required 1 0", exp_q.size(), drbg_next_bits);
      end
   endtask

   task automatic test_field_line();
      logic [31:0] exp = '0;
      repeat (FPR - 1) begin
         field_start = 1'b1;
         @(negedge clk);
         field_start = 1'b0;
         cyc(3);
      end
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      field_start = 1'b1;
      line_start  = 1'b1;
      @(negedge clk);
      field_start = 1'b0;
      line_start  = 1'b0;
      checks++;
      if (line_key_valid !== 1'b1 || line_key !== exp) begin
         errors++;
         $display("FAIL fl_serve: valid %b key %h, required 1 %h", line_key_valid, line_key, exp);
      end
      checks++;
      if (drbg_next_seed !== 1'b1 || drbg_next_bits !== 1'b0) begin
         errors++;
         $display("FAIL fl_seed_first: seed %b next_bits %b, required 1 0", drbg_next_seed, drbg_next_bits);
      end
      @(negedge clk);
      checks++;
      if (drbg_next_seed !== 1'b0 || drbg_next_bits !== 1'b1) begin
         errors++;
         $display("FAIL fl_refill: seed %b next_bits %b, required 0 1", drbg_next_seed, drbg_next_bits);
      end
      last_key = exp;
      wait_refill("fl");
   endtask

   task automatic test_timeout();
      int held = 0;
      enable = 1'b0;
      @(negedge clk);
      exp_q.delete();
      checks++;
      if (line_key !== last_key || drbg_init !== 1'b0 || drbg_next_bits !== 1'b0) begin
         errors++;
         $display("FAIL disable_hold: key %h init %b bits %b, required %h 0 0",
                  line_key, drbg_init, drbg_next_bits, last_key);
      end
      never_ready = 1'b1;
      enable = 1'b1;
      @(negedge clk);
      while (drbg_init === 1'b1 && held < 100) begin
         held++;
         @(negedge clk);
      end
      checks++;
      if (held != TMO || fault !== 1'b1) begin
         errors++;
         $display("FAIL timeout: init held %0d fault %b, required %0d 1", held, fault, TMO);
      end
      cyc(3);
      checks++;
      if ({drbg_init, drbg_next_bits, drbg_next_seed} !== 3'b000 || fault !== 1'b1) begin
         errors++;
         $display("FAIL fault_sticky: req %b fault %b, required 000 1",
                  {drbg_init, drbg_next_bits, drbg_next_seed}, fault);
      end
      enable = 1'b0;
      @(negedge clk);
      checks++;
      if (fault !== 1'b0 || drbg_init !== 1'b0 || underrun_count !== 16'd1) begin
         errors++;
         $display("FAIL fault_clear: fault %b init %b cnt %0d, required 0 0 1", fault, drbg_init, underrun_count);
      end
      enable = 1'b1;
      @(negedge clk);
      checks++;
      if (drbg_init !== 1'b1) begin
         errors++;
         $display("FAIL reinit: drbg_init %b, required 1", drbg_init);
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_serve();
      test_underrun();
      test_reseed();
      test_field_line();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
